// File: rtl/banked_addr_decoder.sv
// -----------------------------------------------------------------------------
// banked_addr_decoder
//
// Decodes a 20-bit CPU address into one of five memory targets and runs the
// handshake for each access. Addresses 00000-BFFFF and C0000-CFFFF go to ROM,
// as does the reset-vector page FFFF0-FFFFF. Up to NUM_WIN 64 KB windows in the
// 00000-BFFFF range are remapped through I/O-written bank registers, so a wider
// ROM (BANK_BITS+16 address bits) can be reached. The remaining ranges select
// pf_vram, ram, eeprom or buffer and complete after WAIT_STATES extra cycles.
//
// Ports
//   clk        : system clock, single clock domain
//   reset_n    : asynchronous active-low reset
//   bank_mask  : board config; set bits come from the bank register,
//                clear bits come from A[19:16]
//   io_wr      : single-cycle bank register write strobe
//   io_addr    : I/O address of the write (bank k at BANK_IO_BASE+k)
//   io_data    : write data, low BANK_BITS bits are stored
//   cpu_addr   : CPU address A[19:0]
//   cpu_req    : level memory request
//   cpu_ready  : one-cycle completion pulse
//   rom_req    : ROM fetch request, held until rom_ack is sampled high
//   rom_addr   : ROM address, stable while rom_req is high
//   rom_ack    : ROM fetch acknowledge
//   sel        : registered one-hot {buffer, eeprom, ram, pf_vram, rom}
// -----------------------------------------------------------------------------
module banked_addr_decoder #(
    parameter int         NUM_WIN      = 2,
    parameter logic [3:0] WIN_BASE     = 4'hA,
    parameter int         BANK_BITS    = 4,
    parameter int         WAIT_STATES  = 1,
    parameter logic [7:0] BANK_IO_BASE = 8'h20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BANK_BITS-1:0]  bank_mask,
    input  logic                  io_wr,
    input  logic [7:0]            io_addr,
    input  logic [7:0]            io_data,
    input  logic [19:0]           cpu_addr,
    input  logic                  cpu_req,
    output logic                  cpu_ready,
    output logic                  rom_req,
    output logic [BANK_BITS+15:0] rom_addr,
    input  logic                  rom_ack,
    output logic [4:0]            sel
);

    localparam int RA_W = BANK_BITS + 16;

    // Last value of the wait counter before leaving WAIT. With no wait
    // states the WAIT state is never entered, so the value is irrelevant.
    localparam logic [2:0] WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    // One-hot positions inside sel
    localparam int SEL_ROM     = 0;
    localparam int SEL_PF_VRAM = 1;
    localparam int SEL_RAM     = 2;
    localparam int SEL_EEPROM  = 3;
    localparam int SEL_BUFFER  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BANK_BITS-1:0] r_bank [NUM_WIN];
    logic [4:0]           r_sel;
    logic [RA_W-1:0]      r_rom_addr;
    logic [2:0]           r_wait_cnt;

    logic [4:0]           w_dec_sel;
    logic [RA_W-1:0]      w_dec_addr;
    logic                 w_dec_rom;
    logic                 w_accept;
    logic [3:0]           w_nib;
    logic [15:0]          w_off;
    logic [BANK_BITS-1:0] w_nib_ext;
    logic                 w_unused_io;

    assign w_nib     = cpu_addr[19:16];
    assign w_off     = cpu_addr[15:0];
    assign w_nib_ext = BANK_BITS'(w_nib);
    assign w_accept  = (r_state == S_IDLE) && cpu_req;

    // Upper io_data bits are only meaningful for wider bank registers.
    assign w_unused_io = ^io_data;

    // Bank registers accept writes in every state. Because the load happens
    // on the same edge that latches a decode, an access accepted in the write
    // cycle still sees the old bank value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_WIN; k++) begin
                r_bank[k] <= '0;
            end
        end else if (io_wr) begin
            for (int k = 0; k < NUM_WIN; k++) begin
                if (io_addr == 8'(BANK_IO_BASE + k)) begin
                    r_bank[k] <= io_data[BANK_BITS-1:0];
                end
            end
        end
    end

    // Address decode. Inside a bank window each high ROM address bit comes
    // either from the bank register or from the CPU nibble, chosen by
    // bank_mask; this lets boards with smaller ROMs leave some bits fixed.
    always_comb begin
        w_dec_sel  = 5'b00000;
        w_dec_addr = '0;
        w_dec_rom  = 1'b0;
        case (w_nib)
            4'hC: begin
                w_dec_sel[SEL_ROM] = 1'b1;
                w_dec_rom          = 1'b1;
                w_dec_addr         = RA_W'(w_off);
            end
            4'hD: begin
                w_dec_sel[SEL_PF_VRAM] = 1'b1;
            end
            4'hE: begin
                w_dec_sel[SEL_RAM] = 1'b1;
            end
            4'hF: begin
                if (w_off[15:14] == 2'b00) begin
                    w_dec_sel[SEL_EEPROM] = 1'b1;
                end else if (w_off[15:13] == 3'b100) begin
                    w_dec_sel[SEL_BUFFER] = 1'b1;
                end else if (w_off[15:4] == 12'hFFF) begin
                    // Reset vectors map to the top of the first 512 KB of ROM
                    w_dec_sel[SEL_ROM] = 1'b1;
                    w_dec_rom          = 1'b1;
                    w_dec_addr         = RA_W'({16'h7FFF, w_off[3:0]});
                end
            end
            default: begin
                w_dec_sel[SEL_ROM] = 1'b1;
                w_dec_rom          = 1'b1;
                w_dec_addr         = RA_W'(cpu_addr);
                for (int k = 0; k < NUM_WIN; k++) begin
                    if (w_nib == 4'(WIN_BASE + k)) begin
                        w_dec_addr = {(r_bank[k] & bank_mask) | (w_nib_ext & ~bank_mask), w_off};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs. RELEASE waits for cpu_req to drop so a
    // request held high is served once rather than repeatedly.
    always_comb begin
        w_next    = r_state;
        rom_req   = 1'b0;
        cpu_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    if (w_dec_rom) begin
                        w_next = S_ROM;
                    end else if (WAIT_STATES == 0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_ROM: begin
                rom_req = 1'b1;
                if (rom_ack) begin
                    w_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                w_next    = S_RELEASE;
            end
            S_RELEASE: begin
                if (!cpu_req) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Decode results are captured once at accept time so rom_addr and sel
    // stay stable for the whole access even if cpu_addr or a bank changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel      <= '0;
            r_rom_addr <= '0;
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_sel      <= w_dec_sel;
            r_rom_addr <= w_dec_addr;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == S_DONE) begin
                r_sel <= '0;
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end
        end
    end

    assign sel      = r_sel;
    assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_banked_addr_decoder.sv
// -----------------------------------------------------------------------------
// tb_banked_addr_decoder
//
// Self-checking bench for banked_addr_decoder with default parameters
// (two windows at A/B, 4-bit banks, one wait state, bank I/O at 0x20).
// A fixed vector table covers every decode range and its edges, hand-written
// sequences cover ack latency, accept-cycle bank writes, reset mid-access and
// a held request, then random accesses are compared with an arithmetic model
// of the address map.
// -----------------------------------------------------------------------------
module tb_banked_addr_decoder;

    localparam int         NUM_WIN      = 2;
    localparam logic [3:0] WIN_BASE     = 4'hA;
    localparam int         BANK_BITS    = 4;
    localparam int         WAIT_STATES  = 1;
    localparam logic [7:0] BANK_IO_BASE = 8'h20;

    logic        clk;
    logic        reset_n;
    logic [3:0]  bank_mask;
    logic        io_wr;
    logic [7:0]  io_addr;
    logic [7:0]  io_data;
    logic [19:0] cpu_addr;
    logic        cpu_req;
    logic        cpu_ready;
    logic        rom_req;
    logic [19:0] rom_addr;
    logic        rom_ack;
    logic [4:0]  sel;

    int vecCount  = 0;
    int missCount = 0;

    int unsigned mBank [NUM_WIN];

    typedef struct {
        logic [19:0] addr;
        logic [3:0]  mask;
        logic [3:0]  b0;
        logic [3:0]  b1;
        logic [4:0]  expSel;
        logic [19:0] expRa;
        bit          isRom;
    } vec_t;

    vec_t vecs [18];

    banked_addr_decoder #(
        .NUM_WIN      (NUM_WIN),
        .WIN_BASE     (WIN_BASE),
        .BANK_BITS    (BANK_BITS),
        .WAIT_STATES  (WAIT_STATES),
        .BANK_IO_BASE (BANK_IO_BASE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bank_mask (bank_mask),
        .io_wr     (io_wr),
        .io_addr   (io_addr),
        .io_data   (io_data),
        .cpu_addr  (cpu_addr),
        .cpu_req   (cpu_req),
        .cpu_ready (cpu_ready),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .sel       (sel)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison; every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeBank(input int k, input logic [7:0] d);
        io_wr   = 1'b1;
        io_addr = 8'(BANK_IO_BASE + k);
        io_data = d;
        tick();
        io_wr   = 1'b0;
    endtask

    // Reference address map, written from the memory map with plain
    // arithmetic on segment number and offset.
    function automatic void refModel(input int unsigned a, input int unsigned b0, input int unsigned b1,
                                     input int unsigned mask, output int unsigned expSel,
                                     output int unsigned expRa, output bit isRom);
        int unsigned seg;
        int unsigned off;
        int unsigned bank;
        seg    = a / 32'h10000;
        off    = a % 32'h10000;
        expSel = 0;
        expRa  = 0;
        isRom  = 1'b0;
        if (seg <= 32'hB) begin
            isRom  = 1'b1;
            expSel = 1;
            if (seg >= 32'(WIN_BASE) && seg < 32'(WIN_BASE) + NUM_WIN) begin
                bank  = (seg == 32'(WIN_BASE)) ? b0 : b1;
                expRa = (((bank & mask) | (seg & ~mask)) & 32'hF) * 32'h10000 + off;
            end else begin
                expRa = a;
            end
        end else if (seg == 32'hC) begin
            isRom  = 1'b1;
            expSel = 1;
            expRa  = off;
        end else if (seg == 32'hD) begin
            expSel = 2;
        end else if (seg == 32'hE) begin
            expSel = 4;
        end else begin
            if (off < 32'h4000) begin
                expSel = 8;
            end else if (off >= 32'h8000 && off < 32'hA000) begin
                expSel = 16;
            end else if (off >= 32'hFFF0) begin
                isRom  = 1'b1;
                expSel = 1;
                expRa  = 32'h7FFF0 + (off % 16);
            end
        end
    endfunction

    // Runs one access from IDLE. Cycle offsets are counted from the accept
    // cycle N; ack is raised during N+ackDelay, a bank/IO write can be issued
    // at cycle N+wrCycle, and cpu_req is held holdExtra cycles past RELEASE.
    task automatic applyStimulus(input logic [19:0] a, input int ackDelay, input int holdExtra,
                                 input bit ackAlways, input int wrCycle, input logic [7:0] wrAddr,
                                 input logic [7:0] wrData, output logic [4:0] selN1,
                                 output logic [19:0] raN1, output int romCycles, output int readyAt,
                                 output int readyCount, output bit raStable, output logic [4:0] selRel);
        cpu_addr = a;
        cpu_req  = 1'b1;
        rom_ack  = ackAlways;
        io_addr  = wrAddr;
        io_data  = wrData;
        io_wr    = (wrCycle == 0);
        tick();
        selN1      = sel;
        raN1       = rom_addr;
        romCycles  = 0;
        readyAt    = -1;
        readyCount = 0;
        raStable   = 1'b1;
        selRel     = 5'b11111;
        for (int c = 1; c <= 40; c++) begin
            io_wr = (wrCycle == c);
            if (rom_req === 1'b1) begin
                romCycles++;
                if (rom_addr !== raN1) raStable = 1'b0;
            end
            if (cpu_ready === 1'b1) begin
                readyCount++;
                if (readyAt < 0) readyAt = c;
            end
            if (readyAt >= 0 && c == readyAt + 1) selRel = sel;
            if (readyAt >= 0 && c == readyAt + 1 + holdExtra) cpu_req = 1'b0;
            if (readyAt >= 0 && c == readyAt + 2 + holdExtra) break;
            rom_ack = ackAlways || (rom_req === 1'b1 && c >= ackDelay);
            tick();
        end
        cpu_req = 1'b0;
        rom_ack = 1'b0;
        io_wr   = 1'b0;
    endtask

    initial begin
        logic [4:0]  selN1;
        logic [19:0] raN1;
        logic [4:0]  selRel;
        int          romCycles;
        int          readyAt;
        int          readyCount;
        bit          raStable;
        int          idleBad;
        int unsigned expSel;
        int unsigned expRa;
        bit          isRom;

        vecs[0]  = '{20'hA1234, 4'hF, 4'h5, 4'h0, 5'b00001, 20'h51234, 1'b1};
        vecs[1]  = '{20'hB0010, 4'h3, 4'h0, 4'hE, 5'b00001, 20'hA0010, 1'b1};
        vecs[2]  = '{20'hE0100, 4'hF, 4'h0, 4'h0, 5'b00100, 20'h00000, 1'b0};
        vecs[3]  = '{20'hF5000, 4'hF, 4'h0, 4'h0, 5'b00000, 20'h00000, 1'b0};
        vecs[4]  = '{20'hFFFF4, 4'hF, 4'h0, 4'h0, 5'b00001, 20'h7FFF4, 1'b1};
        vecs[5]  = '{20'hC1234, 4'hF, 4'h7, 4'h7, 5'b00001, 20'h01234, 1'b1};
        vecs[6]  = '{20'hD0000, 4'hF, 4'h0, 4'h0, 5'b00010, 20'h00000, 1'b0};
        vecs[7]  = '{20'hF3FFF, 4'hF, 4'h0, 4'h0, 5'b01000, 20'h00000, 1'b0};
        vecs[8]  = '{20'hF8000, 4'hF, 4'h0, 4'h0, 5'b10000, 20'h00000, 1'b0};
        vecs[9]  = '{20'hF9FFF, 4'hF, 4'h0, 4'h0, 5'b10000, 20'h00000, 1'b0};
        vecs[10] = '{20'hFA000, 4'hF, 4'h0, 4'h0, 5'b00000, 20'h00000, 1'b0};
        vecs[11] = '{20'h51234, 4'hF, 4'h5, 4'h5, 5'b00001, 20'h51234, 1'b1};
        vecs[12] = '{20'hA0000, 4'h0, 4'h7, 4'h7, 5'b00001, 20'hA0000, 1'b1};
        vecs[13] = '{20'hBFFFF, 4'hC, 4'h3, 4'h6, 5'b00001, 20'h7FFFF, 1'b1};
        vecs[14] = '{20'hFFFEF, 4'hF, 4'h0, 4'h0, 5'b00000, 20'h00000, 1'b0};
        vecs[15] = '{20'hF4000, 4'hF, 4'h0, 4'h0, 5'b00000, 20'h00000, 1'b0};
        vecs[16] = '{20'hFFFFF, 4'hF, 4'h0, 4'h0, 5'b00001, 20'h7FFFF, 1'b1};
        vecs[17] = '{20'h0ABCD, 4'hF, 4'h9, 4'h0, 5'b00001, 20'h0ABCD, 1'b1};

        reset_n   = 1'b0;
        bank_mask = 4'h0;
        io_wr     = 1'b0;
        io_addr   = 8'h00;
        io_data   = 8'h00;
        cpu_addr  = 20'h0;
        cpu_req   = 1'b0;
        rom_ack   = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("reset_sel", 32'(sel), 32'h0);
        checkOutput("reset_rom_req", 32'(rom_req), 32'h0);
        checkOutput("reset_cpu_ready", 32'(cpu_ready), 32'h0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'h0);
        reset_n = 1'b1;
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < 18; i++) begin
            writeBank(0, 8'(vecs[i].b0));
            writeBank(1, 8'(vecs[i].b1));
            bank_mask = vecs[i].mask;
            applyStimulus(vecs[i].addr, 2, 0, 1'b0, -1, 8'h00, 8'h00,
                          selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
            checkOutput($sformatf("tbl%0d_sel", i), 32'(selN1), 32'(vecs[i].expSel));
            if (vecs[i].isRom) begin
                checkOutput($sformatf("tbl%0d_rom_addr", i), 32'(raN1), 32'(vecs[i].expRa));
                checkOutput($sformatf("tbl%0d_rom_cycles", i), romCycles, 2);
                checkOutput($sformatf("tbl%0d_ready_at", i), readyAt, 3);
            end else begin
                checkOutput($sformatf("tbl%0d_rom_cycles", i), romCycles, 0);
                checkOutput($sformatf("tbl%0d_ready_at", i), readyAt, 1 + WAIT_STATES);
            end
            checkOutput($sformatf("tbl%0d_ready_count", i), readyCount, 1);
            checkOutput($sformatf("tbl%0d_sel_release", i), 32'(selRel), 32'h0);
        end

        $display("[TB] rom ack after three cycles");
        writeBank(0, 8'h05);
        bank_mask = 4'hF;
        applyStimulus(20'hA1234, 3, 0, 1'b0, -1, 8'h00, 8'h00,
                      selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
        checkOutput("ack3_rom_addr", 32'(raN1), 32'h51234);
        checkOutput("ack3_rom_cycles", romCycles, 3);
        checkOutput("ack3_ready_at", readyAt, 4);
        checkOutput("ack3_ready_count", readyCount, 1);
        checkOutput("ack3_addr_stable", 32'(raStable), 32'h1);

        $display("[TB] ram access with stray ack");
        applyStimulus(20'hE0100, 1, 0, 1'b1, -1, 8'h00, 8'h00,
                      selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
        checkOutput("ram_sel", 32'(selN1), 32'h04);
        checkOutput("ram_ready_at", readyAt, 2);
        checkOutput("ram_rom_cycles", romCycles, 0);

        $display("[TB] bank write in accept cycle");
        writeBank(0, 8'h01);
        applyStimulus(20'hA0000, 1, 0, 1'b0, 0, 8'h20, 8'h03,
                      selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
        checkOutput("acc_wr_old_bank", 32'(raN1), 32'h10000);
        applyStimulus(20'hA0000, 1, 0, 1'b0, -1, 8'h00, 8'h00,
                      selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
        checkOutput("acc_wr_new_bank", 32'(raN1), 32'h30000);

        $display("[TB] held request");
        applyStimulus(20'hD1000, 1, 6, 1'b0, -1, 8'h00, 8'h00,
                      selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
        checkOutput("hold_ready_count", readyCount, 1);

        $display("[TB] reset during rom fetch");
        writeBank(0, 8'h05);
        bank_mask = 4'hF;
        cpu_addr  = 20'hA1234;
        cpu_req   = 1'b1;
        rom_ack   = 1'b0;
        tick();
        checkOutput("rst_pre_rom_req", 32'(rom_req), 32'h1);
        #2;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        checkOutput("rst_rom_req", 32'(rom_req), 32'h0);
        checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        checkOutput("rst_sel", 32'(sel), 32'h0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'h0);
        tick();
        reset_n = 1'b1;
        idleBad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rom_req !== 1'b0 || cpu_ready !== 1'b0 || sel !== 5'b0) idleBad++;
        end
        checkOutput("rst_no_resume", idleBad, 0);
        applyStimulus(20'hA1234, 1, 0, 1'b0, -1, 8'h00, 8'h00,
                      selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
        checkOutput("rst_bank_cleared", 32'(raN1), 32'h01234);

        $display("[TB] random accesses");
        writeBank(0, 8'h00);
        writeBank(1, 8'h00);
        mBank[0] = 0;
        mBank[1] = 0;
        for (int i = 0; i < 150; i++) begin
            logic [19:0] a;
            int unsigned seg;
            int unsigned off;
            int          ackDelay;
            int          wrCycle;
            int          wrK;
            logic [7:0]  wrData;
            if ($urandom_range(0, 3) == 0) begin
                wrK    = int'($urandom_range(0, 1));
                wrData = 8'($urandom);
                writeBank(wrK, wrData);
                mBank[wrK] = 32'(wrData) & 32'hF;
            end
            bank_mask = 4'($urandom_range(0, 15));
            seg = $urandom_range(0, 15);
            off = $urandom_range(0, 16'hFFFF);
            if (seg == 15) begin
                case ($urandom_range(0, 3))
                    0: off = $urandom_range(0, 16'hFFFF);
                    1: off = 32'hFFF0 + $urandom_range(0, 15);
                    2: off = 32'h8000 + $urandom_range(0, 16'h1FFF);
                    default: off = $urandom_range(0, 16'h3FFF);
                endcase
            end
            a        = 20'(seg * 32'h10000 + off);
            ackDelay = int'($urandom_range(1, 4));
            wrK      = int'($urandom_range(0, 2));
            wrData   = 8'($urandom);
            wrCycle  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1;
            refModel(32'(a), mBank[0], mBank[1], 32'(bank_mask), expSel, expRa, isRom);
            applyStimulus(a, ackDelay, 0, 1'b0, wrCycle, 8'(BANK_IO_BASE + wrK), wrData,
                          selN1, raN1, romCycles, readyAt, readyCount, raStable, selRel);
            checkOutput($sformatf("rnd%0d_sel a=%05h", i, a), 32'(selN1), expSel);
            if (isRom) begin
                checkOutput($sformatf("rnd%0d_rom_addr a=%05h", i, a), 32'(raN1), expRa);
                checkOutput($sformatf("rnd%0d_ready_at", i), readyAt, ackDelay + 1);
                checkOutput($sformatf("rnd%0d_addr_stable", i), 32'(raStable), 32'h1);
            end else begin
                checkOutput($sformatf("rnd%0d_ready_at", i), readyAt, 1 + WAIT_STATES);
                checkOutput($sformatf("rnd%0d_rom_cycles", i), romCycles, 0);
            end
            checkOutput($sformatf("rnd%0d_ready_count", i), readyCount, 1);
            checkOutput($sformatf("rnd%0d_sel_release", i), 32'(selRel), 32'h0);
            if (wrCycle >= 0 && wrK < NUM_WIN) mBank[wrK] = 32'(wrData) & 32'hF;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
